// File: rtl/ara_pkg.sv
// Subset of the Ara vector-unit package that this block depends on:
// the element width and the element type.
package ara_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0] elen_t;

endpackage

// File: rtl/bc_operand_fanout_pkg.sv
// Shared constants for the broadcast operand fanout: consumer slot indices
// and default sizing.
package bc_operand_fanout_pkg;

  localparam int unsigned VmfpuIdx           = 0;
  localparam int unsigned ValuIdx            = 1;
  localparam int unsigned DefaultNrConsumers = 2;
  localparam int unsigned DefaultFifoDepth   = 2;

endpackage

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with synchronous flush. A push into a full FIFO is refused,
// so ready_o is exactly "not full".
module stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push, pop;

  assign ready_o = (cnt_q != CntW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bc_operand_fanout.sv
// Fans one broadcast element out to the local consumers and the next lane,
// remembering which legs were already served so each sees every element once.
module bc_operand_fanout
  import ara_pkg::*;
  import bc_operand_fanout_pkg::*;
#(
  parameter bit          Lane0       = 1'b0,
  parameter bit          LastLane    = 1'b0,
  parameter int unsigned NrConsumers = DefaultNrConsumers,
  parameter int unsigned FifoDepth   = DefaultFifoDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  elen_t                  bc_data_i,
  input  logic                   bc_valid_i,
  output logic                   bc_ready_o,
  output elen_t                  bc_data_o,
  output logic                   bc_valid_o,
  input  logic                   bc_ready_i,
  input  logic [NrConsumers-1:0] cons_en_i,
  output elen_t                  cons_data_o,
  output logic [NrConsumers-1:0] cons_valid_o,
  input  logic [NrConsumers-1:0] cons_ready_i
);

  elen_t                  head_data;
  logic                   head_valid, head_ready;
  logic [NrConsumers-1:0] served_q, served_d, cons_done;
  logic                   fwd_q, fwd_d, fwd_done;

  // Lane 0 is fed by the broadcast buffer, which already holds the element.
  if (Lane0) begin : gen_fall_through
    assign head_data  = bc_data_i;
    assign head_valid = bc_valid_i & rst_ni;
    assign bc_ready_o = head_ready | flush_i;
  end else begin : gen_input_fifo
    stream_fifo #(
      .DEPTH (FifoDepth),
      .T     (elen_t)
    ) i_bc_op_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .data_i  (bc_data_i),
      .valid_i (bc_valid_i),
      .ready_o (bc_ready_o),
      .data_o  (head_data),
      .valid_o (head_valid),
      .ready_i (head_ready)
    );
  end

  always_comb begin
    bc_data_o    = head_data;
    cons_data_o  = head_data;
    cons_valid_o = head_valid ? (cons_en_i & ~served_q) : '0;
    bc_valid_o   = !LastLane && head_valid && !fwd_q;

    cons_done  = ~cons_en_i | served_q | (cons_valid_o & cons_ready_i);
    fwd_done   = LastLane || fwd_q || (bc_valid_o && bc_ready_i);
    head_ready = head_valid && (&cons_done) && fwd_done;

    served_d = served_q;
    fwd_d    = fwd_q;
    // Flush wins over any handshake seen in the same cycle.
    if (flush_i || head_ready) begin
      served_d = '0;
      fwd_d    = 1'b0;
    end else if (head_valid) begin
      served_d = served_q | (cons_valid_o & cons_ready_i);
      fwd_d    = fwd_q | (bc_valid_o & bc_ready_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      served_q <= '0;
      fwd_q    <= 1'b0;
    end else begin
      served_q <= served_d;
      fwd_q    <= fwd_d;
    end
  end

endmodule

// File: tb/tb_bc_operand_fanout.sv
// Directed bench for bc_operand_fanout: a FIFO-fed middle lane (dut0) and a
// fall-through last lane (dut1), checked through per-leg scoreboards.
module tb_bc_operand_fanout;
  import ara_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  elen_t      bc_data = '0;
  logic       bc_valid = 1'b0;
  logic       bc_ready_nx = 1'b0;
  logic [1:0] cons_en = 2'b11;
  logic [1:0] cons_ready = 2'b00;
  logic       bc_ready_out;
  elen_t      bc_data_out;
  logic       bc_valid_out;
  elen_t      cons_data_out;
  logic [1:0] cons_valid_out;

  elen_t      bc1_data = '0;
  logic       bc1_valid = 1'b0;
  logic       bc1_ready_nx = 1'b0;
  logic [1:0] cons1_en = 2'b01;
  logic [1:0] cons1_ready = 2'b01;
  logic       bc1_ready_out;
  elen_t      bc1_data_out;
  logic       bc1_valid_out;
  elen_t      cons1_data_out;
  logic [1:0] cons1_valid_out;

  elen_t qC0[$];
  elen_t qC1[$];
  elen_t qFwd[$];
  elen_t q1C0[$];

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  bc_operand_fanout #(.Lane0(1'b0), .LastLane(1'b0), .NrConsumers(2), .FifoDepth(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .bc_data_i(bc_data), .bc_valid_i(bc_valid), .bc_ready_o(bc_ready_out),
    .bc_data_o(bc_data_out), .bc_valid_o(bc_valid_out), .bc_ready_i(bc_ready_nx),
    .cons_en_i(cons_en), .cons_data_o(cons_data_out),
    .cons_valid_o(cons_valid_out), .cons_ready_i(cons_ready)
  );

  bc_operand_fanout #(.Lane0(1'b1), .LastLane(1'b1), .NrConsumers(2), .FifoDepth(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .bc_data_i(bc1_data), .bc_valid_i(bc1_valid), .bc_ready_o(bc1_ready_out),
    .bc_data_o(bc1_data_out), .bc_valid_o(bc1_valid_out), .bc_ready_i(bc1_ready_nx),
    .cons_en_i(cons1_en), .cons_data_o(cons1_data_out),
    .cons_valid_o(cons1_valid_out), .cons_ready_i(cons1_ready)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: got %0h, expected no delivery", name, act);
  endtask

  // legs: bit0 VMFPU, bit1 VALU, bit2 next lane
  task automatic applyStimulus(input elen_t d, input logic [2:0] legs);
    bc_valid = 1'b1;
    bc_data  = d;
    if (legs[0]) qC0.push_back(d);
    if (legs[1]) qC1.push_back(d);
    if (legs[2]) qFwd.push_back(d);
  endtask

  task automatic applyStimulusLane0(input elen_t d);
    bc1_valid = 1'b1;
    bc1_data  = d;
    q1C0.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every handshake on a leg must deliver the next expected element.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (cons_valid_out[0] && cons_ready[0]) begin
        if (qC0.size() == 0) unexpected("vmfpu_extra", cons_data_out);
        else checkOutput("vmfpu_data", cons_data_out, qC0.pop_front());
      end
      if (cons_valid_out[1] && cons_ready[1]) begin
        if (qC1.size() == 0) unexpected("valu_extra", cons_data_out);
        else checkOutput("valu_data", cons_data_out, qC1.pop_front());
      end
      if (bc_valid_out && bc_ready_nx) begin
        if (qFwd.size() == 0) unexpected("fwd_extra", bc_data_out);
        else checkOutput("fwd_data", bc_data_out, qFwd.pop_front());
      end
      if (cons1_valid_out[0] && cons1_ready[0]) begin
        if (q1C0.size() == 0) unexpected("l0_vmfpu_extra", cons1_data_out);
        else checkOutput("l0_vmfpu_data", cons1_data_out, q1C0.pop_front());
      end
      if (cons1_valid_out[1]) unexpected("l0_valu_valid", 64'(cons1_valid_out));
      if (bc1_valid_out) unexpected("l0_fwd_valid", 64'(bc1_valid_out));
    end
  end

  initial begin
    bc1_valid = 1'b1;
    bc1_data  = 64'h55;
    sample();
    checkOutput("rst_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("rst_fvalid", 64'(bc_valid_out), 64'h0);
    checkOutput("rst_l0_cvalid", 64'(cons1_valid_out), 64'h0);
    tick();
    rst_n = 1'b1;
    bc1_valid = 1'b0;

    // Back-to-back stream, all legs ready
    tick();
    cons_ready = 2'b11;
    bc_ready_nx = 1'b1;
    applyStimulus(64'h11, 3'b111);
    sample();
    checkOutput("s1_latency_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s1_bc_ready", 64'(bc_ready_out), 64'h1);
    tick();
    applyStimulus(64'h22, 3'b111);
    sample();
    checkOutput("s1_e0_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s1_e0_fvalid", 64'(bc_valid_out), 64'h1);
    checkOutput("s1_e0_data", cons_data_out, 64'h11);
    tick();
    applyStimulus(64'h33, 3'b111);
    sample();
    checkOutput("s1_e1_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s1_e1_data", cons_data_out, 64'h22);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s1_e2_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s1_e2_fdata", bc_data_out, 64'h33);
    tick();
    sample();
    checkOutput("s1_idle_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s1_idle_fvalid", 64'(bc_valid_out), 64'h0);

    // Next lane stalled three cycles
    tick();
    bc_ready_nx = 1'b0;
    applyStimulus(64'hAA, 3'b111);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s2_c0_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s2_c0_fvalid", 64'(bc_valid_out), 64'h1);
    tick();
    sample();
    checkOutput("s2_c1_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s2_c1_fvalid", 64'(bc_valid_out), 64'h1);
    checkOutput("s2_c1_fdata", bc_data_out, 64'hAA);
    tick();
    sample();
    checkOutput("s2_c2_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s2_c2_fvalid", 64'(bc_valid_out), 64'h1);
    tick();
    bc_ready_nx = 1'b1;
    sample();
    checkOutput("s2_c3_fvalid", 64'(bc_valid_out), 64'h1);
    tick();
    sample();
    checkOutput("s2_pop_fvalid", 64'(bc_valid_out), 64'h0);
    checkOutput("s2_pop_cvalid", 64'(cons_valid_out), 64'h0);

    // VALU stalled two cycles while the FIFO fills
    tick();
    cons_ready = 2'b01;
    applyStimulus(64'h05, 3'b111);
    tick();
    applyStimulus(64'h06, 3'b111);
    sample();
    checkOutput("s3_c0_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s3_c0_data", cons_data_out, 64'h05);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s3_c1_cvalid", 64'(cons_valid_out), 64'h2);
    checkOutput("s3_c1_fvalid", 64'(bc_valid_out), 64'h0);
    checkOutput("s3_full_ready", 64'(bc_ready_out), 64'h0);
    tick();
    cons_ready = 2'b11;
    sample();
    checkOutput("s3_c2_cvalid", 64'(cons_valid_out), 64'h2);
    checkOutput("s3_c2_ready", 64'(bc_ready_out), 64'h0);
    tick();
    sample();
    checkOutput("s3_next_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s3_next_data", cons_data_out, 64'h06);
    checkOutput("s3_next_ready", 64'(bc_ready_out), 64'h1);
    tick();
    sample();
    checkOutput("s3_idle_cvalid", 64'(cons_valid_out), 64'h0);

    // Flush with two queued elements and VMFPU already served
    tick();
    cons_ready = 2'b01;
    bc_ready_nx = 1'b0;
    applyStimulus(64'h08, 3'b001);
    tick();
    applyStimulus(64'h09, 3'b000);
    sample();
    checkOutput("s5_pre_cvalid", 64'(cons_valid_out), 64'h3);
    tick();
    bc_valid = 1'b0;
    flush = 1'b1;
    cons_ready = 2'b11;
    bc_ready_nx = 1'b1;
    sample();
    checkOutput("s5_served_cvalid", 64'(cons_valid_out), 64'h2);
    checkOutput("s5_full_ready", 64'(bc_ready_out), 64'h0);
    tick();
    flush = 1'b0;
    applyStimulus(64'h77, 3'b111);
    sample();
    checkOutput("s5_post_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s5_post_fvalid", 64'(bc_valid_out), 64'h0);
    checkOutput("s5_post_ready", 64'(bc_ready_out), 64'h1);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s5_new_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s5_new_data", cons_data_out, 64'h77);
    tick();
    sample();
    checkOutput("s5_idle_cvalid", 64'(cons_valid_out), 64'h0);

    // Reset in the middle of an element
    tick();
    cons_ready = 2'b00;
    bc_ready_nx = 1'b0;
    applyStimulus(64'hBB, 3'b000);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s6_pre_cvalid", 64'(cons_valid_out), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s6_rst_fvalid", 64'(bc_valid_out), 64'h0);
    tick();
    cons_ready = 2'b11;
    bc_ready_nx = 1'b1;
    tick();
    rst_n = 1'b1;
    sample();
    checkOutput("s6_rel_cvalid", 64'(cons_valid_out), 64'h0);
    checkOutput("s6_rel_fvalid", 64'(bc_valid_out), 64'h0);
    tick();
    applyStimulus(64'hCC, 3'b111);
    tick();
    bc_valid = 1'b0;
    sample();
    checkOutput("s6_new_cvalid", 64'(cons_valid_out), 64'h3);
    checkOutput("s6_new_data", cons_data_out, 64'hCC);

    // Fall-through last lane, VALU disabled
    tick();
    cons1_ready = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      applyStimulusLane0(64'(k));
      sample();
      checkOutput("s4_cvalid", 64'(cons1_valid_out), 64'h1);
      checkOutput("s4_fvalid", 64'(bc1_valid_out), 64'h0);
      checkOutput("s4_pop", 64'(bc1_ready_out), 64'h1);
      checkOutput("s4_fdata", bc1_data_out, 64'(k));
      tick();
    end
    bc1_valid = 1'b0;
    sample();
    checkOutput("s4_idle_cvalid", 64'(cons1_valid_out), 64'h0);
    tick();
    bc1_valid = 1'b1;
    bc1_data = 64'h99;
    cons1_ready = 2'b00;
    sample();
    checkOutput("s4_stall_ready", 64'(bc1_ready_out), 64'h0);
    checkOutput("s4_stall_cvalid", 64'(cons1_valid_out), 64'h1);
    tick();
    flush = 1'b1;
    sample();
    checkOutput("s4_flush_ready", 64'(bc1_ready_out), 64'h1);
    tick();
    flush = 1'b0;
    bc1_valid = 1'b0;
    cons1_ready = 2'b01;
    sample();
    checkOutput("s4_end_cvalid", 64'(cons1_valid_out), 64'h0);

    tick();
    checkOutput("vmfpu_pending", 64'(qC0.size()), 64'h0);
    checkOutput("valu_pending", 64'(qC1.size()), 64'h0);
    checkOutput("fwd_pending", 64'(qFwd.size()), 64'h0);
    checkOutput("l0_vmfpu_pending", 64'(q1C0.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
